// File: rtl/conv2d_layer_mc_pkg.sv
// ============================================================================
// conv_pkg : shared constants and requantisation helpers for the conv layers
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package conv_pkg;

  localparam int KERNEL_SIZE = 9;

  // Helpers work on a 64-bit signed carrier so any ACC_W/OUT_W up to 64 fits.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int sh);
    logic signed [63:0] r;
    r = v;
    if (sh > 0) r = (v + (64'sd1 <<< (sh - 1))) >>> sh;
    return r;
  endfunction

  function automatic logic signed [63:0] sat_unsigned(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< w) - 64'sd1;
    if (v < 0) return 64'sd0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv2d_layer_mc_line_buffer.sv
// ============================================================================
// line_buffer_mc : two-row history per input channel for a 3x3 window
// Revision       : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module line_buffer_mc #(
  parameter int IMG_W  = 28,
  parameter int CH_IN  = 8,
  parameter int DATA_W = 8,
  parameter int COL_W  = $clog2(IMG_W)
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [COL_W-1:0]          col,
  input  logic [CH_IN*DATA_W-1:0]   in_data,
  output logic [CH_IN*DATA_W-1:0]   r0,
  output logic [CH_IN*DATA_W-1:0]   r1,
  output logic [CH_IN*DATA_W-1:0]   r2
);

  for (genvar ch = 0; ch < CH_IN; ch++) begin : g_ch
    logic [DATA_W-1:0] row_old [IMG_W];
    logic [DATA_W-1:0] row_new [IMG_W];

    // Reading before the write at the same column shifts the column up one row.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        row_old[col] <= row_new[col];
        row_new[col] <= in_data[ch*DATA_W +: DATA_W];
      end
    end

    assign r0[ch*DATA_W +: DATA_W] = row_old[col];
    assign r1[ch*DATA_W +: DATA_W] = row_new[col];
  end

  assign r2 = in_data;

endmodule

`default_nettype wire

// File: rtl/conv2d_layer_mc.sv
// ============================================================================
// conv2d_layer_mc : multi-channel 3x3 valid convolution, bias, requant, clip
// Revision        : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module conv2d_layer_mc
  import conv_pkg::*;
#(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int CH_IN       = 8,
  parameter int CH_OUT      = 16,
  parameter int DATA_W      = 8,
  parameter int WEIGHT_W    = 8,
  parameter int BIAS_W      = 16,
  parameter int ACC_W       = 32,
  parameter int OUT_W       = 8,
  parameter int QUANT_SHIFT = 10,
  parameter int RELU_EN     = 1,
  parameter logic [CH_OUT*CH_IN*KERNEL_SIZE*WEIGHT_W-1:0] WEIGHTS = '0,
  parameter logic [CH_OUT*BIAS_W-1:0]                     BIASES  = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic [CH_IN*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [CH_OUT*OUT_W-1:0]   out_data
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             col_end;
  logic             row_end;

  assign accept  = in_valid && !clr;
  assign col_end = (col == COL_W'(IMG_W - 1));
  assign row_end = (row == ROW_W'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  logic [CH_IN*DATA_W-1:0] lb_row [3];

  line_buffer_mc #(
    .IMG_W (IMG_W),
    .CH_IN (CH_IN),
    .DATA_W(DATA_W),
    .COL_W (COL_W)
  ) u_line_buffer (
    .clk    (clk),
    .wr_en  (accept),
    .col    (col),
    .in_data(in_data),
    .r0     (lb_row[0]),
    .r1     (lb_row[1]),
    .r2     (lb_row[2])
  );

  // Stage 1: window shift register; [ky][2] holds the most recent column.
  logic [DATA_W-1:0] win [CH_IN][3][3];
  logic              v1, l1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ci = 0; ci < CH_IN; ci++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            win[ci][ky][kx] <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      if (accept) begin
        for (int ci = 0; ci < CH_IN; ci++)
          for (int ky = 0; ky < 3; ky++) begin
            win[ci][ky][0] <= win[ci][ky][1];
            win[ci][ky][1] <= win[ci][ky][2];
            win[ci][ky][2] <= lb_row[ky][ci*DATA_W +: DATA_W];
          end
      end
      v1 <= accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
      l1 <= accept && row_end && col_end;
    end
  end

  logic signed [ACC_W-1:0] mac_sum;
  logic signed [ACC_W-1:0] acc_next [CH_OUT];

  always_comb begin
    mac_sum  = '0;
    acc_next = '{default: '0};
    for (int co = 0; co < CH_OUT; co++) begin
      mac_sum = ACC_W'($signed(BIASES[co*BIAS_W +: BIAS_W]));
      for (int ci = 0; ci < CH_IN; ci++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            mac_sum = mac_sum
                    + ACC_W'($signed({1'b0, win[ci][ky][kx]}))
                    * ACC_W'($signed(WEIGHTS[((co*CH_IN + ci)*KERNEL_SIZE + ky*3 + kx)*WEIGHT_W +: WEIGHT_W]));
      acc_next[co] = mac_sum;
    end
  end

  // Stage 2: accumulators, free-running so input gaps never delay an output.
  logic signed [ACC_W-1:0] acc2 [CH_OUT];
  logic                    v2, l2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int co = 0; co < CH_OUT; co++) acc2[co] <= '0;
      v2 <= 1'b0;
      l2 <= 1'b0;
    end else begin
      for (int co = 0; co < CH_OUT; co++) acc2[co] <= acc_next[co];
      v2 <= v1 && !clr;
      l2 <= l1 && !clr;
    end
  end

  logic [CH_OUT*OUT_W-1:0] quant;

  always_comb begin
    quant = '0;
    for (int co = 0; co < CH_OUT; co++) begin
      if (RELU_EN != 0)
        quant[co*OUT_W +: OUT_W] = OUT_W'(sat_unsigned(round_shift(64'(acc2[co]), QUANT_SHIFT), OUT_W));
      else
        quant[co*OUT_W +: OUT_W] = OUT_W'(sat_signed(round_shift(64'(acc2[co]), QUANT_SHIFT), OUT_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= v2 && !clr;
      out_last  <= v2 && l2 && !clr;
      if (v2 && !clr) out_data <= quant;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv2d_layer_mc.sv
// ============================================================================
// tb_conv2d_layer_mc : five 5x5x2->2 configurations against a reference model
// Revision           : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv2d_layer_mc;

  localparam int NI = 5;
  localparam int          W_MODE [NI] = '{0, 1, 1, 2, 3};
  localparam int          QS_T   [NI] = '{0, 0, 0, 10, 9};
  localparam int          RELU_T [NI] = '{1, 1, 0, 1, 0};
  localparam logic [31:0] B_T    [NI] = '{32'h0, 32'h0, 32'h0, 32'h07D0_0000, 32'h04D2_FED4};

  // Weight image, index ((co*2+ci)*9 + ky*3 + kx), one signed byte each.
  function automatic logic [287:0] mk_w(input int mode);
    logic [287:0] v;
    int co, ci, k, w;
    v = '0;
    for (int i = 0; i < 36; i++) begin
      co = i / 18; ci = (i / 9) % 2; k = i % 9;
      case (mode)
        0:       w = 1;
        1:       w = (co == 1) ? -1 : 1;
        2:       w = (k != 8) ? 0 : (co == 0) ? ((ci == 0) ? 100 : 1) : ((ci == 0) ? 1 : 0);
        default: w = ((i * 37 + 11) % 256) - 128;
      endcase
      v[i*8 +: 8] = w[7:0];
    end
    return v;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid;
  logic [15:0] in_data;
  logic        ov [NI];
  logic        ol [NI];
  logic [15:0] od [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    conv2d_layer_mc #(
      .IMG_W(5), .IMG_H(5), .CH_IN(2), .CH_OUT(2), .DATA_W(8), .WEIGHT_W(8),
      .BIAS_W(16), .ACC_W(32), .OUT_W(8), .QUANT_SHIFT(QS_T[g]), .RELU_EN(RELU_T[g]),
      .WEIGHTS(mk_w(W_MODE[g])), .BIASES(B_T[g])
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
      .out_valid(ov[g]), .out_last(ol[g]), .out_data(od[g])
    );
  end

  typedef struct { int due; logic last; logic [NI-1:0][15:0] d; } exp_t;
  typedef struct { logic [7:0] a, b, e0, e1; } dvec_t;
  typedef struct { int pix; logic [15:0] ea, eb, ec; } uvec_t;

  exp_t        q[$];
  dvec_t       dtab [9];
  uvec_t       utab [3];
  logic [15:0] cap_d[$];
  logic [15:0] cap_e[$];
  logic [15:0] held [NI];
  int          img [5][5][2];
  int          mr, mc;
  int          n_tests = 0, n_fail = 0, n_out = 0, n_last = 0;

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [%0d] @%0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] model_out(input int inst, input int r, input int c);
    logic [287:0] wv;
    logic [31:0]  bv;
    longint       acc;
    logic [15:0]  res;
    int           qs;
    wv = mk_w(W_MODE[inst]); bv = B_T[inst]; qs = QS_T[inst]; res = '0;
    for (int co = 0; co < 2; co++) begin
      acc = longint'($signed(bv[co*16 +: 16]));
      for (int ci = 0; ci < 2; ci++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            acc += longint'(img[r-2+ky][c-2+kx][ci])
                 * longint'($signed(wv[((co*2 + ci)*9 + ky*3 + kx)*8 +: 8]));
      if (qs > 0) acc = (acc + (longint'(1) << (qs - 1))) >>> qs;
      if (RELU_T[inst] != 0) begin
        if (acc < 0) acc = 0; else if (acc > 255) acc = 255;
      end else begin
        if (acc < -128) acc = -128; else if (acc > 127) acc = 127;
      end
      res[co*8 +: 8] = acc[7:0];
    end
    return res;
  endfunction

  // One clock of stimulus; the model tracks frame position and queues expectations.
  task automatic drive(input logic v, input logic [15:0] d, input logic c);
    exp_t x;
    int   e;
    in_valid = v; in_data = d; clr = c;
    @(posedge clk);
    e = int'($time / 10);
    if (c) begin
      q.delete(); mr = 0; mc = 0;
    end else if (v) begin
      img[mr][mc][0] = d[7:0];
      img[mr][mc][1] = d[15:8];
      if (mr >= 2 && mc >= 2) begin
        x.due = e + 2;
        x.last = (mr == 4 && mc == 4);
        for (int i = 0; i < NI; i++) x.d[i] = model_out(i, mr, mc);
        q.push_back(x);
      end
      if (mc == 4) begin mc = 0; mr = (mr == 4) ? 0 : mr + 1; end
      else mc++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'($urandom), 1'b0);
  endtask

  task automatic run_frame(input int kind, input int val, input int max_gap);
    logic [15:0] d;
    int k;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        k = (r - 2) * 3 + (c - 2);
        case (kind)
          0:       d = {val[7:0], val[7:0]};
          1:       d = {8'(255 - (r*5 + c)*3), 8'((r*5 + c)*7)};
          2:       d = 16'($urandom);
          default: d = (r >= 2 && c >= 2) ? {dtab[k].b, dtab[k].a} : 16'h0;
        endcase
        if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
        drive(1'b1, d, 1'b0);
      end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_valid", i, ov[i], 0);
      chk("rst_last", i, ol[i], 0);
      chk("rst_data", i, od[i], 0);
      held[i] = '0;
    end
    q.delete(); mr = 0; mc = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : mon
    int   e;
    logic due_now;
    if (rst_n) begin
      e = int'(($time - 5) / 10);
      due_now = (q.size() > 0) && (q[0].due == e);
      for (int i = 0; i < NI; i++) begin
        chk("out_valid", i, ov[i], due_now);
        if (due_now) begin
          chk("out_data", i, od[i], q[0].d[i]);
          chk("out_last", i, ol[i], q[0].last);
          held[i] = q[0].d[i];
        end else begin
          chk("hold_data", i, od[i], held[i]);
        end
      end
      if (ov[0]) n_out++;
      if (ov[0] && ol[0]) n_last++;
      if (ov[3]) cap_d.push_back(od[3]);
      if (ov[4]) cap_e.push_back(od[4]);
      if (due_now) void'(q.pop_front());
    end
  end

  initial begin
    dtab[0] = '{8'd15,  8'd36,  8'd2,  8'd2};
    dtab[1] = '{8'd15,  8'd35,  8'd1,  8'd2};
    dtab[2] = '{8'd5,   8'd12,  8'd1,  8'd2};
    dtab[3] = '{8'd5,   8'd11,  8'd0,  8'd2};
    dtab[4] = '{8'd0,   8'd0,   8'd0,  8'd2};
    dtab[5] = '{8'd1,   8'd0,   8'd0,  8'd2};
    dtab[6] = '{8'd255, 8'd255, 8'd25, 8'd2};
    dtab[7] = '{8'd10,  8'd240, 8'd1,  8'd2};
    dtab[8] = '{8'd20,  8'd124, 8'd2,  8'd2};
    utab[0] = '{1,  16'h1212, 16'h0012, 16'hEE12};
    utab[1] = '{20, 16'hFFFF, 16'h00FF, 16'h807F};
    utab[2] = '{0,  16'h0000, 16'h0000, 16'h0000};

    rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    do_reset();

    // Uniform frames: saturation, ReLU and signed clip on the held output.
    for (int t = 0; t < 3; t++) begin
      run_frame(0, utab[t].pix, 0);
      idle(6);
      chk("uniform_A", t, od[0], utab[t].ea);
      chk("uniform_B", t, od[1], utab[t].eb);
      chk("uniform_C", t, od[2], utab[t].ec);
    end

    // Rounding vectors: one table record per window position.
    cap_d.delete();
    run_frame(3, 0, 0);
    idle(6);
    chk("round_count", 3, cap_d.size(), 9);
    for (int k = 0; k < 9 && k < cap_d.size(); k++)
      chk("round_vec", k, cap_d[k], {dtab[k].e1, dtab[k].e0});

    // Ramp image without and with random input gaps.
    for (int t = 0; t < 3; t++) begin
      cap_e.delete();
      run_frame(1, 0, (t == 0) ? 0 : 5);
      idle(6);
      chk("ramp_count", t, cap_e.size(), 9);
      chk("ramp_queue", t, q.size(), 0);
    end

    // Abort at pixel (3,1) with in_valid high, then a restarted frame.
    for (int p = 0; p < 16; p++) drive(1'b1, 16'($urandom), 1'b0);
    drive(1'b1, 16'($urandom), 1'b1);
    n_out = 0;
    idle(4);
    chk("clr_silence", 0, n_out, 0);
    run_frame(2, 0, 2);
    idle(6);
    chk("clr_restart_count", 0, n_out, 9);

    // Back-to-back frames with no bubble.
    n_out = 0; n_last = 0;
    run_frame(2, 0, 0);
    run_frame(2, 0, 0);
    idle(6);
    chk("b2b_count", 0, n_out, 18);
    chk("b2b_last", 0, n_last, 2);

    // Asynchronous reset mid-frame, then a clean frame.
    for (int p = 0; p < 13; p++) drive(1'b1, 16'($urandom), 1'b0);
    do_reset();
    n_out = 0; n_last = 0;
    run_frame(2, 0, 1);
    idle(6);
    chk("post_rst_count", 0, n_out, 9);
    chk("post_rst_last", 0, n_last, 1);
    chk("final_queue", 0, q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
